fp_add_normalizer_pipe: RTL
===========================

Name: fp_add_normalizer_pipe

Overview:
Parametrised, pipelined post-addition normaliser for the FPU adder datapath. It accepts the raw sum mantissa, including the carry bit, and the pre-normalisation biased exponent. It performs carry right-shift or leading-zero left-shift, then flags overflow, underflow and zero. Valid/ready handshake on both sides, 2-cycle latency, full throughput; it sits between the mantissa adder and the rounder.

Parameters:
EXP_W, 8, biased exponent width
MAN_W, 24, mantissa width including hidden bit
TAG_W, 4, sideband tag carried alongside each operation
DENORM_EN, 1, 1 = produce subnormal results; 0 = flush underflow to zero

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  input operation valid
in_ready  out  1  block can accept input this cycle
in_e  in  EXP_W  biased exponent before normalisation
in_m  in  MAN_W+1  sum mantissa; bit MAN_W is the adder carry
in_tag  in  TAG_W  sideband tag
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_e  out  EXP_W  normalised exponent
out_m  out  MAN_W  normalised mantissa
out_tag  out  TAG_W  tag of the result
out_sticky  out  1  nonzero bit lost by the carry right-shift
out_ovf  out  1  exponent overflow; result is infinity
out_uf  out  1  result is subnormal or flushed
out_zero  out  1  mantissa is zero

Behaviour:
- One clock (clk). Reset is synchronous, active-high (rst).
- Reset clears both stage-valid bits and all output registers to 0. in_ready is 1 on the first cycle after reset.
- Transfer occurs on valid&&ready. Latency from input transfer to out_valid is 2 cycles when out_ready stays high.
- Stall rules:
  - s2 advances when !s2_valid || out_ready.
  - s1 advances when !s1_valid || s2 advances.
  - in_ready = s1 advances.
- Payload registers load only on advance, so output holds stable while out_valid && !out_ready. No drop, no duplication, order preserved.
- Stage 1 registers: in_e, in_m, in_tag, carry = in_m[MAN_W], zero = (in_m == 0), and lz = leading-zero count of in_m[MAN_W-1:0] from the lzc sub-module. lz width is $clog2(MAN_W+1).
- Stage 2 selects the first matching case:
  - zero: out_m = 0, out_e = 0, out_zero = 1.
  - carry: out_m = in_m[MAN_W:1], out_sticky = in_m[0], e = in_e+1 computed at EXP_W+1 bits.
    - If e >= 2^EXP_W-1: out_e = all-ones, out_m = 0, out_ovf = 1.
    - Otherwise out_e = e.
  - normal, lz < in_e: out_m = in_m << lz, out_e = in_e - lz.
  - underflow, lz >= in_e, in_e >= 1: shift = in_e-1, out_e = 0, out_uf = 1.
  - in_e = 0 (input already subnormal): shift 0, out_e = 0. out_uf = 1 if the mantissa is nonzero.
- When DENORM_EN = 0, any out_uf case forces out_m = 0 and out_e = 0; out_uf stays 1 and out_zero stays 0.
- Flags are mutually exclusive except that out_sticky can accompany a carry result. All flags are 0 when out_valid = 0.
- Exponent arithmetic uses EXP_W+1 bits; no silent wrap.
- If rst asserts mid-operation, in-flight data is discarded and out_valid = 0 on the next cycle.
- Simultaneous in transfer and out transfer with both stages full is allowed; sustained throughput is 1 op/cycle.

Decomposition:
- Package fp_norm_pkg:
  - LZ_W = $clog2(MAN_W+1)
  - EXP_MAX constant
  - struct norm_flags_t {ovf, uf, zero, sticky}
  - enum norm_case_t {ZERO, CARRY, NORMAL, UNDERFLOW}
- Sub-module lzc (parameter W): combinational leading-zero counter, tree structure, returns W for all-zero input.
- Top level holds the pipeline registers and handshake logic.

Test Plan:
1. in_e = 0x80, in_m = 0x0000001 -> out_m = 0x800000, out_e = 0x69, flags 0, out_valid exactly 2 cycles after input transfer.
2. in_e = 0x80, in_m = 0x1800001 -> out_m = 0xC00000, out_e = 0x81, out_sticky = 1.
3. in_e = 0xFE, in_m = 0x1000000 -> out_e = 0xFF, out_m = 0, out_ovf = 1.
4. in_e = 0x05, in_m = 0x0000100 -> out_m = 0x001000, out_e = 0x00, out_uf = 1. Same input with DENORM_EN = 0 -> out_m = 0, out_e = 0, out_uf = 1.
5. in_m = 0, in_e = 0x42 -> out_zero = 1, out_m = 0, out_e = 0.
6. Backpressure, tags 1..6 back-to-back:
   - Stimulus: out_ready low on cycles 3-6.
   - Required: in_ready drops once both stages are full; output stays stable while stalled; tags emerge in order with no loss. Assert rst mid-stream -> out_valid = 0 next cycle, in_ready = 1.

Source files
------------

// File: rtl/fp_norm_pkg.sv
// Shared types and constants for the FPU adder post-addition normaliser.
package fp_norm_pkg;

    localparam int unsigned DEF_EXP_W = 8;
    localparam int unsigned DEF_MAN_W = 24;
    localparam int unsigned LZ_W      = $clog2(DEF_MAN_W + 1);
    localparam int unsigned EXP_MAX   = (1 << DEF_EXP_W) - 1;

    typedef struct packed {
        logic ovf;
        logic uf;
        logic zero;
        logic sticky;
    } norm_flags_t;

    typedef enum logic [1:0] {
        ZERO,
        CARRY,
        NORMAL,
        UNDERFLOW
    } norm_case_t;

endpackage

// File: rtl/fp_add_normalizer_pipe_lzc.sv
// Combinational leading-zero counter built as a binary reduction tree.
// Returns W when the input is all zeros.
module lzc #(
    parameter int unsigned W = 24
) (
    input  logic [W-1:0]             din,
    output logic [$clog2(W+1)-1:0]   count
);

    localparam int unsigned L  = $clog2(W);
    localparam int unsigned P  = 1 << L;
    localparam int unsigned OW = $clog2(W + 1);

    logic [P-1:0] padded;
    logic [L:0]   cnt [L+1][P];
    logic         zf  [L+1][P];

    // Level 0 holds one node per bit (MSB first); each level merges node pairs.
    always_comb begin
        padded = '0;
        padded[P-1 -: W] = din;
        for (int k = 0; k <= int'(L); k++) begin
            for (int i = 0; i < int'(P); i++) begin
                cnt[k][i] = '0;
                zf[k][i]  = 1'b0;
            end
        end
        for (int i = 0; i < int'(P); i++) begin
            zf[0][i] = ~padded[int'(P) - 1 - i];
        end
        for (int k = 1; k <= int'(L); k++) begin
            for (int i = 0; i < int'(P >> k); i++) begin
                zf[k][i]  = zf[k-1][2*i] & zf[k-1][2*i+1];
                cnt[k][i] = zf[k-1][2*i]
                          ? (L+1)'((1 << (k-1)) + int'(cnt[k-1][2*i+1]))
                          : cnt[k-1][2*i];
            end
        end
        count = zf[L][0] ? OW'(W) : OW'(cnt[L][0]);
    end

endmodule

// File: rtl/fp_add_normalizer_pipe.sv
// Two-stage post-addition normaliser: stage 1 captures operands and leading-zero
// count, stage 2 applies carry/normalise/underflow shifts and raises flags.
module fp_add_normalizer_pipe #(
    parameter int unsigned EXP_W     = 8,
    parameter int unsigned MAN_W     = 24,
    parameter int unsigned TAG_W     = 4,
    parameter bit          DENORM_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [EXP_W-1:0] in_e,
    input  logic [MAN_W:0]   in_m,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [EXP_W-1:0] out_e,
    output logic [MAN_W-1:0] out_m,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_sticky,
    output logic             out_ovf,
    output logic             out_uf,
    output logic             out_zero
);

    import fp_norm_pkg::*;

    localparam int unsigned LZW = $clog2(MAN_W + 1);
    localparam int unsigned EW1 = EXP_W + 1;
    localparam logic [EW1-1:0] E_TOP = {1'b0, {EXP_W{1'b1}}};

    logic             s1_valid, s1_carry, s1_zero;
    logic [EXP_W-1:0] s1_e;
    logic [MAN_W:0]   s1_m;
    logic [TAG_W-1:0] s1_tag;
    logic [LZW-1:0]   s1_lz, lz_c;
    logic             s1_adv, s2_adv;

    logic             valid_q;
    logic [EXP_W-1:0] e_q, e_n;
    logic [MAN_W-1:0] m_q, m_n, m_lo;
    logic [TAG_W-1:0] tag_q;
    norm_flags_t      flags_q, flags_n;
    norm_case_t       ncase;
    logic [EW1-1:0]   e_wide, e_inc, lz_wide;

    lzc #(.W(MAN_W)) u_lzc (
        .din   (in_m[MAN_W-1:0]),
        .count (lz_c)
    );

    assign s2_adv   = !valid_q || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_carry <= 1'b0;
            s1_zero  <= 1'b0;
            s1_e     <= '0;
            s1_m     <= '0;
            s1_tag   <= '0;
            s1_lz    <= '0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            s1_carry <= in_m[MAN_W];
            s1_zero  <= (in_m == '0);
            s1_e     <= in_e;
            s1_m     <= in_m;
            s1_tag   <= in_tag;
            s1_lz    <= lz_c;
        end
    end

    // Case selection and shift/exponent arithmetic for stage 2.
    always_comb begin
        flags_n = '0;
        e_n     = '0;
        m_n     = '0;
        m_lo    = s1_m[MAN_W-1:0];
        e_wide  = {1'b0, s1_e};
        e_inc   = e_wide + EW1'(1);
        lz_wide = EW1'(s1_lz);
        ncase   = NORMAL;
        if (s1_zero)                ncase = ZERO;
        else if (s1_carry)          ncase = CARRY;
        else if (lz_wide < e_wide)  ncase = NORMAL;
        else                        ncase = UNDERFLOW;

        case (ncase)
            ZERO: flags_n.zero = 1'b1;
            CARRY: begin
                flags_n.sticky = s1_m[0];
                if (e_inc >= E_TOP) begin
                    flags_n.ovf = 1'b1;
                    e_n         = '1;
                end else begin
                    e_n = e_inc[EXP_W-1:0];
                    m_n = s1_m[MAN_W:1];
                end
            end
            NORMAL: begin
                e_n = s1_e - EXP_W'(s1_lz);
                m_n = m_lo << s1_lz;
            end
            UNDERFLOW: begin
                flags_n.uf = 1'b1;
                if (DENORM_EN) begin
                    m_n = (s1_e == '0) ? m_lo : (m_lo << (s1_e - EXP_W'(1)));
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            e_q     <= '0;
            m_q     <= '0;
            tag_q   <= '0;
            flags_q <= '0;
        end else if (s2_adv) begin
            valid_q <= s1_valid;
            e_q     <= s1_valid ? e_n : '0;
            m_q     <= s1_valid ? m_n : '0;
            tag_q   <= s1_valid ? s1_tag : '0;
            flags_q <= s1_valid ? flags_n : '0;
        end
    end

    assign out_valid  = valid_q;
    assign out_e      = e_q;
    assign out_m      = m_q;
    assign out_tag    = tag_q;
    assign out_sticky = flags_q.sticky;
    assign out_ovf    = flags_q.ovf;
    assign out_uf     = flags_q.uf;
    assign out_zero   = flags_q.zero;

endmodule
